// File: rtl/hazard_unit_pkg.sv
// Shared types for the pipeline hazard controller.
package hazard_unit_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN,
    DWAIT,
    HALTED
  } hazard_state_t;

  localparam regbits_t REG_ZERO = 5'd0;

  // A load in EX feeding a source of the instruction in ID; $0 is hardwired.
  function automatic logic load_use(input logic ex_load, input regbits_t wsel,
                                    input regbits_t rs, input regbits_t rt);
    return ex_load && (wsel != REG_ZERO) && ((wsel == rs) || (wsel == rt));
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline status in, latch controls and counters out.
interface hazard_unit_if #(parameter int CNT_W = 16);
  import hazard_unit_pkg::*;

  logic             ihit;
  logic             dhit;
  regbits_t         id_rs;
  regbits_t         id_rt;
  logic             ex_dREN;
  regbits_t         ex_wsel;
  logic             ex_brtaken;
  logic             mem_dREN;
  logic             mem_dWEN;
  logic             mem_halt;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             memwb_flush;
  logic             halt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Core side: reports pipeline status, consumes controls.
  modport master (
    output ihit, dhit, id_rs, id_rt, ex_dREN, ex_wsel, ex_brtaken,
           mem_dREN, mem_dWEN, mem_halt,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           memwb_flush, halt, stall_cnt, flush_cnt
  );

  // Hazard unit side.
  modport slave (
    input  ihit, dhit, id_rs, id_rt, ex_dREN, ex_wsel, ex_brtaken,
           mem_dREN, mem_dWEN, mem_halt,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           memwb_flush, halt, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter: sticks at all-ones, never wraps.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] cnt
);

  // Clear wins over increment; increment stops at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (clear)              cnt <= '0;
    else if (inc && (~cnt != '0)) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/hazard_unit.sv
// Per-cycle advance/hold/bubble decisions for the 5-stage pipeline latches,
// plus stall and branch-flush performance counters.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic          CLK,
  input  logic          nRST,
  hazard_unit_if.slave  hu
);

  hazard_state_t state;
  logic          dwait;
  logic          loaduse;
  logic          halted;

  assign dwait   = (hu.mem_dREN | hu.mem_dWEN) & ~hu.dhit;
  assign loaduse = load_use(hu.ex_dREN, hu.ex_wsel, hu.id_rs, hu.id_rt);
  assign halted  = (state == HALTED);

  // Data-wait tracking and sticky halt; a pending data wait blocks halt so the
  // halting instruction never retires past an unfinished memory access.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= RUN;
      hu.halt <= 1'b0;
    end else begin
      case (state)
        RUN, DWAIT: begin
          if (hu.mem_halt && !dwait) begin
            state   <= HALTED;
            hu.halt <= 1'b1;
          end else if (state == RUN && dwait) begin
            state <= DWAIT;
          end else if (state == DWAIT && hu.dhit) begin
            state <= RUN;
          end
        end
        default: begin
          state   <= HALTED;
          hu.halt <= 1'b1;
        end
      endcase
    end
  end

  // Prioritised latch control; flushes inject bubbles regardless of enables.
  always_comb begin
    hu.pc_en       = 1'b0;
    hu.ifid_en     = 1'b0;
    hu.ifid_flush  = 1'b0;
    hu.idex_en     = 1'b0;
    hu.idex_flush  = 1'b0;
    hu.exmem_en    = 1'b0;
    hu.memwb_flush = 1'b0;
    if (halted) begin
      // everything frozen
    end else if (dwait) begin
      // whole pipe holds; MEM/WB gets a bubble so nothing retires twice
      hu.memwb_flush = 1'b1;
    end else if (hu.ex_brtaken) begin
      // target loads even on an fetch miss; wrong-path IF and ID squashed
      hu.pc_en      = 1'b1;
      hu.ifid_en    = 1'b1;
      hu.ifid_flush = 1'b1;
      hu.idex_en    = 1'b1;
      hu.idex_flush = 1'b1;
      hu.exmem_en   = 1'b1;
    end else if (loaduse) begin
      // hold PC and ID, one bubble into EX
      hu.idex_en    = 1'b1;
      hu.idex_flush = 1'b1;
      hu.exmem_en   = 1'b1;
    end else if (!hu.ihit) begin
      // fetch miss: bubble into ID, rest drains
      hu.ifid_en    = 1'b1;
      hu.ifid_flush = 1'b1;
      hu.idex_en    = 1'b1;
      hu.exmem_en   = 1'b1;
    end else begin
      hu.pc_en    = 1'b1;
      hu.ifid_en  = 1'b1;
      hu.idex_en  = 1'b1;
      hu.exmem_en = 1'b1;
    end
  end

  logic stall_inc;
  logic flush_inc;

  assign stall_inc = ~halted & ~hu.pc_en;
  assign flush_inc = ~halted & ~dwait & hu.ex_brtaken;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (CLK),
    .rst_n (nRST),
    .inc   (stall_inc),
    .clear (1'b0),
    .cnt   (hu.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (CLK),
    .rst_n (nRST),
    .inc   (flush_inc),
    .clear (1'b0),
    .cnt   (hu.flush_cnt)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed vectors; expected responses queued by the driver, checked by a
// negedge monitor.
module tb_hazard_unit;

  logic CLK;
  logic nRST;

  hazard_unit_if #(.CNT_W(16)) bus ();

  hazard_unit #(.CNT_W(16)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .hu   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush, halt}
  localparam logic [7:0] NORM = 8'b1101_0100;
  localparam logic [7:0] LUSE = 8'b0001_1100;
  localparam logic [7:0] BRCH = 8'b1111_1100;
  localparam logic [7:0] MISS = 8'b0111_0100;
  localparam logic [7:0] DWT  = 8'b0000_0010;
  localparam logic [7:0] HLT  = 8'b0000_0001;

  typedef struct packed {
    logic [7:0]  ctl;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t  exp_q[$];
  string nm_q[$];
  int    total = 0;
  int    bad   = 0;

  task automatic drive(input logic ihit, input logic dhit, input logic [4:0] rs,
                       input logic [4:0] rt, input logic exd, input logic [4:0] ws,
                       input logic br, input logic mr, input logic mw, input logic mh);
    bus.ihit       = ihit;
    bus.dhit       = dhit;
    bus.id_rs      = rs;
    bus.id_rt      = rt;
    bus.ex_dREN    = exd;
    bus.ex_wsel    = ws;
    bus.ex_brtaken = br;
    bus.mem_dREN   = mr;
    bus.mem_dWEN   = mw;
    bus.mem_halt   = mh;
  endtask

  task automatic idle();
    drive(1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
  endtask

  task automatic expect_(input string nm, input logic [7:0] ctl,
                         input logic [15:0] sc, input logic [15:0] fc);
    exp_t e;
    e.ctl = ctl; e.sc = sc; e.fc = fc;
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  // One cycle: inputs applied just after the edge; sc/fc are the counter
  // values expected during this cycle (before this cycle's increment lands).
  task automatic v(input string nm, input logic ihit, input logic dhit,
                   input logic [4:0] rs, input logic [4:0] rt, input logic exd,
                   input logic [4:0] ws, input logic br, input logic mr,
                   input logic mw, input logic mh, input logic [7:0] ctl,
                   input logic [15:0] sc, input logic [15:0] fc, input bit chk);
    @(posedge CLK);
    #1;
    drive(ihit, dhit, rs, rt, exd, ws, br, mr, mw, mh);
    if (chk) expect_(nm, ctl, sc, fc);
  endtask

  // Reset dropped mid-cycle; checked while nRST is still low.
  task automatic reset_mid(input string nm);
    @(posedge CLK);
    #1;
    idle();
    #1;
    nRST = 1'b0;
    expect_(nm, NORM, 16'd0, 16'd0);
    @(negedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  // Monitor: compare whenever a response is pending.
  always @(negedge CLK) begin
    if (exp_q.size() != 0) begin
      exp_t        e;
      string       n;
      logic [7:0]  act;
      e   = exp_q.pop_front();
      n   = nm_q.pop_front();
      act = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en, bus.idex_flush,
             bus.exmem_en, bus.memwb_flush, bus.halt};
      total++;
      if (act !== e.ctl) begin
        bad++;
        $display("FAIL %s ctl: got %b want %b", n, act, e.ctl);
      end
      total++;
      if (bus.stall_cnt !== e.sc) begin
        bad++;
        $display("FAIL %s stall_cnt: got %0h want %0h", n, bus.stall_cnt, e.sc);
      end
      total++;
      if (bus.flush_cnt !== e.fc) begin
        bad++;
        $display("FAIL %s flush_cnt: got %0h want %0h", n, bus.flush_cnt, e.fc);
      end
    end
  end

  initial begin
    nRST = 1'b0;
    idle();
    expect_("reset", NORM, 16'd0, 16'd0);
    @(negedge CLK);
    #1;
    nRST = 1'b1;

    //  name          ihit dhit rs  rt exd ws br mr mw mh  ctl   sc  fc
    v("idle0",        1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, NORM, 16'd0, 16'd0, 1);
    v("luse_rs",      1, 0, 5'd5, 5'd1, 1, 5'd5, 0, 0, 0, 0, LUSE, 16'd0, 16'd0, 1);
    v("after_luse",   1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, NORM, 16'd1, 16'd0, 1);
    v("reg0_exempt",  1, 0, 5'd0, 5'd0, 1, 5'd0, 0, 0, 0, 0, NORM, 16'd1, 16'd0, 1);
    v("luse_rt",      1, 0, 5'd3, 5'd7, 1, 5'd7, 0, 0, 0, 0, LUSE, 16'd1, 16'd0, 1);
    v("load_nomatch", 1, 0, 5'd8, 5'd9, 1, 5'd7, 0, 0, 0, 0, NORM, 16'd2, 16'd0, 1);
    v("match_noload", 1, 0, 5'd5, 5'd5, 0, 5'd5, 0, 0, 0, 0, NORM, 16'd2, 16'd0, 1);
    v("br_luse_miss", 0, 0, 5'd5, 5'd0, 1, 5'd5, 1, 0, 0, 0, BRCH, 16'd2, 16'd0, 1);
    v("after_br",     1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, NORM, 16'd2, 16'd1, 1);
    v("imiss",        0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, MISS, 16'd2, 16'd1, 1);
    v("after_miss",   1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, NORM, 16'd3, 16'd1, 1);
    // store waits 3 cycles with a taken branch parked in EX
    v("dwait1",       1, 0, 5'd0, 5'd0, 0, 5'd0, 1, 0, 1, 0, DWT,  16'd3, 16'd1, 1);
    v("dwait2",       1, 0, 5'd0, 5'd0, 0, 5'd0, 1, 0, 1, 0, DWT,  16'd4, 16'd1, 1);
    v("dwait3",       1, 0, 5'd0, 5'd0, 0, 5'd0, 1, 0, 1, 0, DWT,  16'd5, 16'd1, 1);
    v("dhit_br",      1, 1, 5'd0, 5'd0, 0, 5'd0, 1, 0, 1, 0, BRCH, 16'd6, 16'd1, 1);
    v("after_dhit",   1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, NORM, 16'd6, 16'd2, 1);
    // load wait masks a load-use and a fetch miss
    v("ldwait_luse",  0, 0, 5'd4, 5'd0, 1, 5'd4, 0, 1, 0, 0, DWT,  16'd6, 16'd2, 1);
    v("ld_dhit",      1, 1, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 0, NORM, 16'd7, 16'd2, 1);
    // halt: the halting cycle itself advances normally
    v("halt_in_mem",  1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 1, NORM, 16'd7, 16'd2, 1);
    v("halted1",      1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, HLT,  16'd7, 16'd2, 1);
    v("halted_busy",  0, 0, 5'd2, 5'd0, 1, 5'd2, 1, 0, 1, 0, HLT,  16'd7, 16'd2, 1);
    v("halted2",      0, 0, 5'd0, 5'd0, 0, 5'd0, 1, 0, 0, 0, HLT,  16'd7, 16'd2, 1);
    reset_mid("reset_mid_halt");
    v("post_reset",   1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, NORM, 16'd0, 16'd0, 1);
    // halt blocked while a data access is outstanding
    v("halt_dwait",   1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 1, DWT,  16'd0, 16'd0, 1);
    v("halt_dhit",    1, 1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 1, NORM, 16'd1, 16'd0, 1);
    v("halted3",      1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, HLT,  16'd1, 16'd0, 1);
    reset_mid("reset_mid2");

    // saturation: 2^16+3 forced stall cycles
    for (int i = 0; i < 65539; i++)
      v("sat_fill",   0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, MISS, 16'd0, 16'd0, 0);
    v("sat_hold",     0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, MISS, 16'hFFFF, 16'd0, 1);
    v("sat_nowrap",   1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, NORM, 16'hFFFF, 16'd0, 1);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge CLK);
    #1;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline control block for the 5-stage MIPS core; sits upstream of the forwarding unit.
- Decides, each cycle, which pipeline latches advance, hold or take a bubble: PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
- Causes handled: load-use hazards that forwarding cannot cover, taken-branch flushes, instruction-fetch misses, data-memory waits, and halt.
- Keeps saturating stall and flush performance counters.

Parameters:
- CNT_W, 16, width of each performance counter.

Ports:
- CLK  in  1  system clock
- nRST  in  1  asynchronous active-low reset
- ihit  in  1  instruction fetch completed this cycle
- dhit  in  1  data access completed this cycle
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- ex_dREN  in  1  instruction in EX is a load
- ex_wsel  in  5  destination register of the instruction in EX
- ex_brtaken  in  1  branch/jump resolved taken in EX
- mem_dREN  in  1  load in MEM
- mem_dWEN  in  1  store in MEM
- mem_halt  in  1  halt instruction in MEM
- pc_en  out  1  PC register load enable
- ifid_en  out  1  IF/ID enable
- ifid_flush  out  1  IF/ID loads a bubble
- idex_en  out  1  ID/EX enable
- idex_flush  out  1  ID/EX loads a bubble
- exmem_en  out  1  EX/MEM enable
- memwb_flush  out  1  MEM/WB loads a bubble
- halt  out  1  processor halted (registered)
- stall_cnt  out  CNT_W  cycles with pc_en=0 while not halted, saturating
- flush_cnt  out  CNT_W  taken-branch flushes, saturating

Behaviour:
- Clock and reset: one clock (CLK); asynchronous active-low reset nRST.
- Reset state:
  - state=RUN, halt=0, stall_cnt=0, flush_cnt=0.
  - Combinational outputs follow the inputs immediately after reset.
  - Reset mid-operation: state returns to RUN, halt clears and both counters clear within the same cycle nRST falls.
- State machine:
  - States: RUN, DWAIT, HALTED.
  - RUN -> DWAIT when (mem_dREN|mem_dWEN) and dhit=0.
  - DWAIT -> RUN on dhit=1.
  - RUN or DWAIT -> HALTED on mem_halt=1, provided no data wait is pending.
  - HALTED is sticky until nRST.
- Derived terms:
  - dwait = (mem_dREN|mem_dWEN) & ~dhit.
  - loaduse = ex_dREN & (ex_wsel!=0) & (ex_wsel==id_rs | ex_wsel==id_rt).
- Output priority (highest first); outputs are combinational from inputs and state, except halt and the counters:
  1. HALTED: every enable=0, all flushes=0, halt=1.
  2. dwait:
     - pc_en=ifid_en=idex_en=exmem_en=0.
     - memwb_flush=1.
     - An ex_brtaken, loaduse or ihit in the same cycle is ignored; the branch stays in EX and re-asserts later.
  3. ex_brtaken:
     - pc_en=1 (target loaded regardless of ihit).
     - ifid_flush=1, idex_flush=1, others advance.
     - flush_cnt+1. A simultaneous loaduse is squashed by the flush.
  4. loaduse:
     - pc_en=0, ifid_en=0, idex_flush=1, EX/MEM and MEM/WB advance.
     - Exactly one bubble per load-use pair.
  5. ~ihit:
     - pc_en=0, ifid_flush=1, later stages advance.
  6. Otherwise all enables=1, all flushes=0.
- Flush vs enable: a flush output forces its latch to load a bubble even when the matching enable is 0.
- Halt timing: halt registers one cycle after mem_halt is sampled. The halt instruction itself is allowed into MEM/WB.
- Counters:
  - stall_cnt increments in any cycle where pc_en=0 and state!=HALTED.
  - Both counters saturate at all-ones and never wrap.
  - Counters are held while HALTED.
- Register $0 never creates a load-use hazard.

Decomposition:
- cpu_types_pkg gains:
  - hazard_state_t enum {RUN, DWAIT, HALTED};
  - regbits_t (5-bit register index), if not already present.
- One sub-module, sat_counter, parameterised by width, with inc and clear inputs. It is instantiated twice.

Test Plan:
- Load-use: ex_dREN=1, ex_wsel=5, id_rs=5, ihit=1 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1; stall_cnt 0->1.
- $0 exemption: ex_dREN=1, ex_wsel=0, id_rt=0 -> all enables=1, no flush.
- Branch plus load-use: ex_brtaken=1 with a loaduse condition and ihit=0 -> pc_en=1, ifid_flush=1, idex_flush=1; flush_cnt=1.
- Data wait:
  - mem_dWEN=1 with dhit=0 for 3 cycles, then dhit=1; ex_brtaken held at 1 throughout.
  - Expected: state=DWAIT for 3 cycles; pc_en=exmem_en=0 and memwb_flush=1 in those cycles; flush_cnt unchanged until the cycle after dhit; stall_cnt=3.
- Halt then reset:
  - mem_halt=1 -> halt=1 from the next edge; all enables 0 thereafter; counters frozen.
  - Drop nRST mid-cycle -> halt=0 and counters=0 immediately.
- Saturation: preload via 2^CNT_W+3 forced-stall cycles (ihit=0) -> stall_cnt=16'hFFFF, no wrap.
